// File: rtl/galoi_lfsr.sv
// ---------------------------------------------------------------------------
// galoi_lfsr
//   Free-running right-shift Galois LFSR used as a PRBS / pattern source.
//   Defaults give the maximal-length x^16+x^14+x^13+x^11+1 sequence
//   (period 65535, never zero).
//
// Parameters
//   WIDTH  register width in bits (>= 2)
//   TAPS   feedback mask; bit i set means state bit i takes the feedback bit.
//          TAPS[WIDTH-1] must be 1 so the MSB receives the feedback bit.
//   SEED   reset / lock-up recovery value; a zero SEED is replaced by 1
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous reset, active low (0 = reset, 1 = run)
//   out_lfsr  current LFSR state, taken directly from the state register
// ---------------------------------------------------------------------------
module galoi_lfsr #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] out_lfsr
);

    // An all-zero seed would lock the register up, so fall back to 1.
    localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

    logic             rel_q;
    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] state_nxt;

    // Reset release synchroniser. Assertion is asynchronous; release is
    // sampled into rel_q first, and the state register (itself reset to SEED
    // and only enabled by rel_q) forms the second stage. The first advance
    // therefore always lands on the 2nd rising edge after rst goes high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rel_q <= 1'b0;
        else      rel_q <= 1'b1;
    end

    // Right-shift Galois step. The all-zero state cannot occur in normal
    // operation; if an upset produces it, reload the seed instead of sticking.
    always_comb begin
        state_nxt = SEED_EFF;
        if (state != '0)
            state_nxt = {1'b0, state[WIDTH-1:1]} ^ (state[0] ? TAPS : '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       state <= SEED_EFF;
        else if (rel_q) state <= state_nxt;
    end

    assign out_lfsr = state;

endmodule

// File: tb/tb_galoi_lfsr.sv
// ---------------------------------------------------------------------------
// tb_galoi_lfsr
//   Self-checking bench for galoi_lfsr: default 16-bit instance plus an
//   8-bit variant (TAPS=8'hB8, SEED=8'h01) sharing clock and reset.
// ---------------------------------------------------------------------------
module tb_galoi_lfsr;

    logic        clk;
    logic        rst;
    logic [15:0] out16;
    logic [7:0]  out8;

    int checks = 0;
    int errors = 0;

    galoi_lfsr dut (
        .clk      (clk),
        .rst      (rst),
        .out_lfsr (out16)
    );

    galoi_lfsr #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .out_lfsr (out8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: treat the state as an integer; each step halves
    // it and, if the dropped bit was odd, folds the tap mask back in.
    function automatic int model_step(input int s, input int taps, input int seed);
        if (s == 0) return seed;
        return (s / 2) ^ (((s % 2) == 1) ? taps : 0);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int exp16;
        int exp8;
    } vec_t;

    // Waits for the next rising edge and settles past it.
    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    // Release reset between edges and verify the two-edge release latency.
    task automatic release_and_check(input string tag);
        @(negedge clk);
        rst = 1'b1;
        step_edge();
        check({tag, "_hold16"}, int'(out16), 'hACE1);
        check({tag, "_hold8"},  int'(out8),  'h01);
        step_edge();
        check({tag, "_first16"}, int'(out16), 'hE270);
        check({tag, "_first8"},  int'(out8),  'hB8);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int   m16, m8;
        bit   seen[65536];
        int   zero_cnt, dup_cnt, early_cnt, model_bad, ret8, zero8;

        vecs[0] = '{'hACE1, 'h01};
        vecs[1] = '{'hE270, 'hB8};
        vecs[2] = '{'h7138, 'h5C};
        vecs[3] = '{'h389C, 'h2E};
        vecs[4] = '{'h1C4E, 'h17};
        vecs[5] = '{'h0E27, 'hB3};
        vecs[6] = '{'hB313, 'hE1};
        vecs[7] = '{'hED89, 'hC8};

        // ---- reset held across several edges ----
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step_edge();
            check("reset16", int'(out16), 'hACE1);
            check("reset8",  int'(out8),  'h01);
        end

        // ---- release and initial sequence from the table ----
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step_edge();
            check($sformatf("seq16[%0d]", i), int'(out16), vecs[i].exp16);
            check($sformatf("seq8[%0d]", i),  int'(out8),  vecs[i].exp8);
        end
        m16 = 'hED89;
        m8  = 'hC8;

        // ---- random runs interrupted by async reset at random offsets ----
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(5, 40);
            for (int i = 0; i < n; i++) begin
                step_edge();
                m16 = model_step(m16, 'hB400, 'hACE1);
                m8  = model_step(m8,  'hB8,   'h01);
                check("run16", int'(out16), m16);
                check("run8",  int'(out8),  m8);
            end
            @(posedge clk);
            #($urandom_range(1, 4));
            rst = 1'b0;
            #1;
            check("async16", int'(out16), 'hACE1);
            check("async8",  int'(out8),  'h01);
            release_and_check("rerun");
            m16 = 'hE270;
            m8  = 'hB8;
        end

        // ---- full period from SEED ----
        rst = 1'b0;
        @(negedge clk);
        release_and_check("period");
        // Step 1 has already happened; rebuild the scoreboard from SEED.
        for (int i = 0; i < 65536; i++) seen[i] = 1'b0;
        seen['hACE1] = 1'b1;
        seen['hE270] = 1'b1;
        m16 = 'hE270;
        m8  = 'hB8;
        zero_cnt = 0; dup_cnt = 0; early_cnt = 0; model_bad = 0;
        ret8 = 0; zero8 = 0;
        for (int k = 2; k <= 65535; k++) begin
            step_edge();
            m16 = model_step(m16, 'hB400, 'hACE1);
            m8  = model_step(m8,  'hB8,   'h01);
            if (int'(out16) != m16 || int'(out8) != m8) model_bad++;
            if (out16 == 16'h0000) zero_cnt++;
            if (out8 == 8'h00) zero8++;
            if (out8 == 8'h01 && ret8 == 0) ret8 = k;
            if (k < 65535) begin
                if (out16 == 16'hACE1) early_cnt++;
                if (seen[out16]) dup_cnt++;
                seen[out16] = 1'b1;
            end
        end
        check("period_return", int'(out16), 'hACE1);
        check("period_model",  model_bad, 0);
        check("period_zero",   zero_cnt,  0);
        check("period_early",  early_cnt, 0);
        check("period_dup",    dup_cnt,   0);
        check("period8",       ret8,      255);
        check("period8_zero",  zero8,     0);

        // ---- lock-up recovery after an injected all-zero state ----
        @(negedge clk);
        force dut.state = 16'h0000;
        #1;
        release dut.state;
        #1;
        check("lockup_zero", int'(out16), 0);
        step_edge();
        check("lockup_seed", int'(out16), 'hACE1);
        step_edge();
        check("lockup_next", int'(out16), 'hE270);
        step_edge();
        check("lockup_next2", int'(out16), 'h7138);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
